fp_mul_pipe: RTL and testbench

- Parametrised, 3-stage pipelined IEEE-754-style floating-point multiplier with valid/ready handshaking on both sides.
- Generalises the combinational single-precision multiplier:
  - configurable exponent and mantissa widths;
  - round-to-nearest-even;
  - correct NaN/Inf/zero handling;
  - separate exception flags, registered with each result.
- Sits between the operand register file / issue logic and the FPU result writeback in the FP ALU.

---
 rtl/fp_mul_pipe.sv | 198 +++++++++++++++++++
 tb/tb_fp_mul_pipe.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_mul_pipe.sv
// fp_mul_pipe: 3-stage pipelined floating-point multiplier.
// Rounding is round-to-nearest-even. Denormal inputs are flushed to zero.
// Exception flags are registered alongside each result.
//   clk, rst_n           : clock (rising edge), async active-low reset
//   in_valid / in_ready  : operand handshake (a, b = {sign, exp, frac})
//   out_valid / out_ready: result handshake
//   product              : rounded result
//   flag_ovf/unf/inv     : overflow, underflow (flush) and invalid flags
module fp_mul_pipe #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23,
  localparam int unsigned W = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] product,
  output logic         flag_ovf,
  output logic         flag_unf,
  output logic         flag_inv
);

  localparam int unsigned M1   = MAN_W + 1;
  localparam int unsigned PW   = 2 * M1;
  localparam int unsigned EW   = EXP_W + 2;
  localparam int unsigned BIAS = (1 << (EXP_W - 1)) - 1;
  localparam int unsigned EMAX = (1 << EXP_W) - 1;
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, MAN_W'(1) << (MAN_W - 1)};

  typedef enum logic [1:0] {
    SC_NORM,
    SC_ZERO,
    SC_INF,
    SC_INV
  } spec_e;

  // Whole pipeline freezes while a result waits on downstream
  logic stall;
  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;

  // ---------------- stage 1: classify operands, add exponents ----------------
  logic                    sa, sb;
  logic [EXP_W-1:0]        ea, eb;
  logic [MAN_W-1:0]        fa, fb;
  logic                    a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  spec_e                   code_c;
  logic signed [EW-1:0]    e_c;

  assign sa = a[W-1];
  assign sb = b[W-1];
  assign ea = a[W-2 -: EXP_W];
  assign eb = b[W-2 -: EXP_W];
  assign fa = a[MAN_W-1:0];
  assign fb = b[MAN_W-1:0];

  always_comb begin
    a_zero = (ea == '0);
    b_zero = (eb == '0);
    a_inf  = (ea == '1) && (fa == '0);
    b_inf  = (eb == '1) && (fb == '0);
    a_nan  = (ea == '1) && (fa != '0);
    b_nan  = (eb == '1) && (fb != '0);
    // Biased sum minus one bias; wraps modulo 2^EW, read back as signed
    e_c    = EW'(ea) + EW'(eb) - EW'(BIAS);
    code_c = SC_NORM;
    if (a_nan || b_nan || (a_zero && b_inf) || (b_zero && a_inf)) begin
      code_c = SC_INV;
    end else if (a_inf || b_inf) begin
      code_c = SC_INF;
    end else if (a_zero || b_zero) begin
      code_c = SC_ZERO;
    end
  end

  logic                 s1_valid;
  logic                 s1_sign;
  logic signed [EW-1:0] s1_e;
  spec_e                s1_code;
  logic [M1-1:0]        s1_ma, s1_mb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_e     <= '0;
      s1_code  <= SC_NORM;
      s1_ma    <= '0;
      s1_mb    <= '0;
    end else if (!stall) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_sign <= sa ^ sb;
        s1_e    <= e_c;
        s1_code <= code_c;
        s1_ma   <= {1'b1, fa};
        s1_mb   <= {1'b1, fb};
      end
    end
  end

  // ---------------- stage 2: mantissa multiply ----------------
  logic                 s2_valid;
  logic                 s2_sign;
  logic signed [EW-1:0] s2_e;
  spec_e                s2_code;
  logic [PW-1:0]        s2_prod;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_sign  <= 1'b0;
      s2_e     <= '0;
      s2_code  <= SC_NORM;
      s2_prod  <= '0;
    end else if (!stall) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_sign <= s1_sign;
        s2_e    <= s1_e;
        s2_code <= s1_code;
        s2_prod <= PW'(s1_ma) * PW'(s1_mb);
      end
    end
  end

  // ---------------- stage 3: normalise, round, pack ----------------
  logic [PW-1:0]        norm;
  logic signed [EW-1:0] e_n, e_r;
  logic [M1-1:0]        mant;
  logic                 guard, sticky, round_up, carry;
  logic [M1:0]          rnd;
  logic [MAN_W-1:0]     frac_r;
  logic [W-1:0]         prod_c;
  logic                 ovf_c, unf_c, inv_c;

  always_comb begin
    // Product of two [1,2) mantissas lies in [1,4); left-align so the MSB is the hidden bit
    norm     = s2_prod[PW-1] ? s2_prod : {s2_prod[PW-2:0], 1'b0};
    e_n      = s2_e + EW'(s2_prod[PW-1]);
    mant     = norm[PW-1 -: M1];
    guard    = norm[M1-1];
    sticky   = |norm[M1-2:0];
    round_up = guard & (sticky | mant[0]);
    rnd      = {1'b0, mant} + (M1 + 1)'(round_up);
    carry    = rnd[M1];
    // On carry-out the mantissa is exactly 10..0, so dropping one bit keeps it exact
    frac_r   = carry ? rnd[MAN_W:1] : rnd[MAN_W-1:0];
    e_r      = e_n + EW'(carry);

    prod_c = {s2_sign, e_r[EXP_W-1:0], frac_r};
    ovf_c  = 1'b0;
    unf_c  = 1'b0;
    inv_c  = 1'b0;
    case (s2_code)
      SC_INV: begin
        prod_c = QNAN;
        inv_c  = 1'b1;
      end
      SC_INF:  prod_c = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      SC_ZERO: prod_c = {s2_sign, {(W-1){1'b0}}};
      default: begin
        if (e_r >= $signed(EW'(EMAX))) begin
          prod_c = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          ovf_c  = 1'b1;
        end else if (e_r[EW-1] || (e_r == '0)) begin
          prod_c = {s2_sign, {(W-1){1'b0}}};
          unf_c  = 1'b1;
        end
      end
    endcase
  end

  // Output register: holds product and flags steady during a stall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      product   <= '0;
      flag_ovf  <= 1'b0;
      flag_unf  <= 1'b0;
      flag_inv  <= 1'b0;
    end else if (!stall) begin
      out_valid <= s2_valid;
      if (s2_valid) begin
        product  <= prod_c;
        flag_ovf <= ovf_c;
        flag_unf <= unf_c;
        flag_inv <= inv_c;
      end
    end
  end

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Self-checking bench for fp_mul_pipe (FP32 defaults): directed cases,
// random streams under backpressure, full-rate throughput and mid-flight reset.
module tb_fp_mul_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a, b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] product;
  logic        flag_ovf, flag_unf, flag_inv;
  logic [2:0]  flags;

  assign flags = {flag_ovf, flag_unf, flag_inv};

  fp_mul_pipe #(.EXP_W(8), .MAN_W(23)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .flag_ovf  (flag_ovf),
    .flag_unf  (flag_unf),
    .flag_inv  (flag_inv)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference: exact integer product, then RNE via remainder against half-ulp.
  // Returns {product, ovf, unf, inv}.
  function automatic logic [34:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
    int ex, ey, be, sh;
    bit zx, zy, ix, iy, nx, ny;
    logic s;
    longint unsigned mx, my, p, q, rem, half;
    s  = x[31] ^ y[31];
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    zx = (ex == 0);
    zy = (ey == 0);
    ix = (ex == 255) && (x[22:0] == 0);
    iy = (ey == 255) && (y[22:0] == 0);
    nx = (ex == 255) && (x[22:0] != 0);
    ny = (ey == 255) && (y[22:0] != 0);
    if (nx || ny || (zx && iy) || (zy && ix)) return {32'h7FC00000, 3'b001};
    if (ix || iy) return {s, 8'hFF, 23'd0, 3'b000};
    if (zx || zy) return {s, 31'd0, 3'b000};
    mx = 64'(x[22:0]) | 64'h800000;
    my = 64'(y[22:0]) | 64'h800000;
    p  = mx * my;
    sh = p[47] ? 24 : 23;
    q    = p >> sh;
    rem  = p & ((64'd1 << sh) - 64'd1);
    half = 64'd1 << (sh - 1);
    if (rem > half || (rem == half && q[0])) q = q + 64'd1;
    if (q == (64'd1 << 24)) begin
      q  = q >> 1;
      sh = sh + 1;
    end
    be = ex + ey - 127 + sh - 23;
    if (be >= 255) return {s, 8'hFF, 23'd0, 3'b100};
    if (be <= 0)   return {s, 31'd0, 3'b010};
    return {s, 8'(be), q[22:0], 3'b000};
  endfunction

  function automatic logic [31:0] rand_normal();
    return {1'($urandom_range(0, 1)), 8'($urandom_range(64, 190)), 23'($urandom)};
  endfunction

  // Scoreboard: expected results queued at transfer-in, compared at transfer-out
  logic [34:0] exp_q[$];
  bit          sb_on = 1'b0;
  int          pops = 0;
  logic        was_stalled = 1'b0;
  logic [35:0] held;

  always @(negedge clk) begin
    if (sb_on && rst_n) begin
      check("in_ready", 64'(in_ready), 64'(!(out_valid && !out_ready)));
      if (was_stalled) check("stall_hold", 64'({out_valid, product, flags}), 64'({1'b1, held[34:0]}));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("extra_result", 64'(exp_q.size()), 64'd1);
        else begin
          check("result", 64'({product, flags}), 64'(exp_q.pop_front()));
          pops <= pops + 1;
        end
      end
      if (in_valid && in_ready) exp_q.push_back(ref_mul(a, b));
      was_stalled <= out_valid && !out_ready;
      held        <= {1'b0, product, flags};
    end else begin
      was_stalled <= 1'b0;
    end
  end

  // Single op on an empty pipe with out_ready=1; checks exact 3-cycle latency.
  // Entered and left at posedge+#1.
  task automatic run_one(input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] ep, input logic [2:0] ef, input string tag);
    a = x;
    b = y;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check({tag, "_lat1"}, 64'(out_valid), 64'd0);
    @(posedge clk); @(negedge clk);
    check({tag, "_lat2"}, 64'(out_valid), 64'd0);
    @(posedge clk); @(negedge clk);
    check({tag, "_valid"}, 64'(out_valid), 64'd1);
    check({tag, "_prod"}, 64'(product), 64'(ep));
    check({tag, "_flags"}, 64'(flags), 64'(ef));
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d done", n_pass, n_chk);
    $fatal(1);
  end

  initial begin
    int          sent, guard, stale;
    bit          acc;
    logic [31:0] ov_mask;

    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    out_ready = 1'b1;

    // Reset
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_prod", 64'(product), 64'd0);
    check("rst_flags", 64'(flags), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases
    run_one(32'h3FC00000, 32'h40000000, 32'h40400000, 3'b000, "basic");
    run_one(32'hC0000000, 32'h40400000, 32'hC0C00000, 3'b000, "sign");
    run_one(32'h3F800001, 32'h3FC00000, 32'h3FC00002, 3'b000, "rne_tie");
    run_one(32'h3F800001, 32'h3F800001, 32'h3F800002, 3'b000, "no_round");
    run_one(32'h7F000000, 32'h7F000000, 32'h7F800000, 3'b100, "ovf");
    run_one(32'h00800000, 32'h00800000, 32'h00000000, 3'b010, "unf");
    run_one(32'h00000000, 32'h7F800000, 32'h7FC00000, 3'b001, "inv");
    run_one(32'hFF800000, 32'h40000000, 32'hFF800000, 3'b000, "inf");

    // Backpressure: 8 back-to-back pairs, random out_ready
    pops  = 0;
    sb_on = 1'b1;
    sent  = 0;
    guard = 0;
    while (sent < 8 && guard < 1000) begin
      out_ready = 1'($urandom_range(0, 1));
      a = rand_normal();
      b = rand_normal();
      in_valid = 1'b1;
      acc = 1'b0;
      while (!acc && guard < 1000) begin
        @(negedge clk);
        acc = in_ready;
        @(posedge clk); #1;
        guard++;
        if (!acc) out_ready = 1'($urandom_range(0, 1));
      end
      if (acc) sent++;
    end
    in_valid = 1'b0;
    check("bp_sent", 64'(sent), 64'd8);
    guard = 0;
    while (exp_q.size() != 0 && guard < 200) begin
      out_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      guard++;
    end
    check("bp_drain", 64'(exp_q.size()), 64'd0);
    check("bp_count", 64'(pops), 64'd8);
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Full-rate throughput with arbitrary bit patterns (specials included)
    pops    = 0;
    ov_mask = '0;
    for (int c = 0; c < 26; c++) begin
      in_valid = (c < 20);
      if (c < 20) begin
        a = $urandom;
        b = $urandom;
      end
      @(negedge clk);
      ov_mask[c] = out_valid;
      @(posedge clk); #1;
    end
    check("tput_mask", 64'(ov_mask), 64'h7FFFF8);
    check("tput_count", 64'(pops), 64'd20);
    check("tput_queue", 64'(exp_q.size()), 64'd0);
    sb_on = 1'b0;

    // Reset with 3 ops in flight
    for (int i = 0; i < 3; i++) begin
      a = rand_normal();
      b = rand_normal();
      in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("pre_rst_valid", 64'(out_valid), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_prod", 64'(product), 64'd0);
    check("mid_rst_flags", 64'(flags), 64'd0);
    check("mid_rst_in_ready", 64'(in_ready), 64'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    stale = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid) stale++;
    end
    check("no_stale", 64'(stale), 64'd0);
    @(posedge clk); #1;
    run_one(32'h3FC00000, 32'h40000000, 32'h40400000, 3'b000, "post_rst");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
